// File: rtl/npc_pkg.sv
// Shared types and defaults for the next-PC generator and its return-address stack.
package npc_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int RAS_DEPTH_DEF = 4;

    // Which source drives pc_next this cycle; also consumed by trace/debug logic.
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_BRANCH,
        SEL_SEQ
    } npc_sel_t;

endpackage

// File: rtl/next_pc_logic_ras_stack.sv
// Return-address stack: circular buffer with a write pointer and depth count.
// A push while full overwrites the oldest entry, so later pops only ever see the
// most recent DEPTH return addresses. A pop while empty changes nothing.
// overflow/underflow are single-cycle event strobes; stickiness lives in the parent.
module ras_stack
    import npc_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int W     = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           push_data,
    output logic [W-1:0]           top,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   depth_q, depth_d;

    assign full  = (depth_q == (PTR_W+1)'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;
    // Pointer addresses the next free slot, so the top sits one below it.
    assign top   = mem_q[ptr_q - PTR_W'(1)];

    // Next pointer/depth and event strobes; pop takes precedence over push.
    always_comb begin
        ptr_d     = ptr_q;
        depth_d   = depth_q;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (pop) begin
            if (empty) begin
                underflow = 1'b1;
            end else begin
                ptr_d   = ptr_q - PTR_W'(1);
                depth_d = depth_q - (PTR_W+1)'(1);
            end
        end else if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (full) begin
                overflow = 1'b1;
            end else begin
                depth_d = depth_q + (PTR_W+1)'(1);
            end
        end
    end

    // Pointer and depth registers; reset empties the stack.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            depth_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
        end
    end

    // Entry storage; contents need no reset because depth gates their use.
    always_ff @(posedge clk) begin
        if (push && !pop && !reset) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/next_pc_logic.sv
// Next-PC generator: priority mux over stall/ret/call/branch/sequential plus the
// sticky RAS error flags. pc_next is combinational so the PC register loads it
// on the same edge.
// Build option: define NPC_REL_BRANCH_EN to treat branch_target as a signed
// offset from pc_cur; otherwise branch_target is absolute.
module next_pc_logic
    import npc_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          pc_cur,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [ADDR_W-1:0]          branch_target,
    input  logic                       call,
    input  logic [ADDR_W-1:0]          call_target,
    input  logic                       ret,
    input  logic                       clear_flags,
    output logic [ADDR_W-1:0]          pc_next,
    output logic [$clog2(RAS_DEPTH):0] ras_depth,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);

    npc_sel_t          sel;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] branch_dest;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_ovf_evt;
    logic              ras_unf_evt;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    assign pc_inc = pc_cur + ADDR_W'(1);

`ifdef NPC_REL_BRANCH_EN
    assign branch_dest = pc_cur + branch_target;
`else
    assign branch_dest = branch_target;
`endif

    // Request priority: stall > ret > call > branch > sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (stall)             sel = SEL_HOLD;
        else if (ret)          sel = SEL_RET;
        else if (call)         sel = SEL_CALL;
        else if (branch_taken) sel = SEL_BRANCH;
    end

    // Next-PC mux; a return on an empty stack falls through to the sequential PC.
    always_comb begin
        pc_next = pc_inc;
        if (reset) begin
            pc_next = '0;
        end else begin
            unique case (sel)
                SEL_HOLD:   pc_next = pc_cur;
                SEL_RET:    pc_next = ras_empty ? pc_inc : ras_top;
                SEL_CALL:   pc_next = call_target;
                SEL_BRANCH: pc_next = branch_dest;
                default:    pc_next = pc_inc;
            endcase
        end
    end

    assign ras_push = !reset && (sel == SEL_CALL);
    assign ras_pop  = !reset && (sel == SEL_RET);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .depth     (ras_depth),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (ras_ovf_evt),
        .underflow (ras_unf_evt)
    );

    // Sticky flags: a new event beats a simultaneous clear.
    always_comb begin
        ovf_d = ras_ovf_evt | (ovf_q & ~clear_flags);
        unf_d = ras_unf_evt | (unf_q & ~clear_flags);
    end

    // Flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_next_pc_logic.sv
// Bench for next_pc_logic: table of single-cycle vectors with expected pc_next
// checked combinationally and expected post-edge RAS state queued and checked
// after the edge, plus hand sequences for reset/free-run and mid-stack reset.
module tb_next_pc_logic;

    localparam int AW = 12;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_cur;
    logic          stall, branch_taken, call, ret, clear_flags;
    logic [AW-1:0] branch_target, call_target;
    logic [AW-1:0] pc_next;
    logic [2:0]    ras_depth;
    logic          ras_overflow, ras_underflow;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    next_pc_logic #(.ADDR_W(AW), .RAS_DEPTH(RD)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_cur),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .call          (call),
        .call_target   (call_target),
        .ret           (ret),
        .clear_flags   (clear_flags),
        .pc_next       (pc_next),
        .ras_depth     (ras_depth),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    typedef struct {
        string         name;
        logic          st, rt, cl, br, clr;
        logic [AW-1:0] pc, bt, ct;
        logic [AW-1:0] exp_pc;
        logic [2:0]    exp_depth;
        logic          exp_ovf, exp_unf;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] depth;
        logic       ovf, unf;
    } post_t;

    vec_t  vecs[$];
    post_t exp_q[$];

    function automatic vec_t mk(string name, logic st, logic rt, logic cl, logic br,
                                logic clr, logic [AW-1:0] pc, logic [AW-1:0] bt,
                                logic [AW-1:0] ct, logic [AW-1:0] exp_pc,
                                logic [2:0] d, logic ovf, logic unf);
        vec_t v;
        v.name = name; v.st = st; v.rt = rt; v.cl = cl; v.br = br; v.clr = clr;
        v.pc = pc; v.bt = bt; v.ct = ct; v.exp_pc = exp_pc;
        v.exp_depth = d; v.exp_ovf = ovf; v.exp_unf = unf;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; ret = 0; call = 0; branch_taken = 0; clear_flags = 0;
        branch_target = '0; call_target = '0;
    endtask

    // Drive one vector, check pc_next before the edge, check queued state after it.
    task automatic apply(vec_t v);
        post_t e;
        stall = v.st; ret = v.rt; call = v.cl; branch_taken = v.br; clear_flags = v.clr;
        pc_cur = v.pc; branch_target = v.bt; call_target = v.ct;
        e.name = v.name; e.depth = v.exp_depth; e.ovf = v.exp_ovf; e.unf = v.exp_unf;
        exp_q.push_back(e);
        #1;
        chk({v.name, ".pc_next"}, 32'(pc_next), 32'(v.exp_pc));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk({e.name, ".depth"}, 32'(ras_depth), 32'(e.depth));
        chk({e.name, ".ovf"}, 32'(ras_overflow), 32'(e.ovf));
        chk({e.name, ".unf"}, 32'(ras_underflow), 32'(e.unf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] br_exp;

    initial begin
`ifdef NPC_REL_BRANCH_EN
        br_exp = 12'h00E;
`else
        br_exp = 12'hFFE;
`endif
        //            name        st rt cl br clr pc      bt      ct      exp_pc  d  ov un
        vecs.push_back(mk("seq",    0,0,0,0,0, 12'h123, 12'h000, 12'h000, 12'h124, 0, 0,0));
        vecs.push_back(mk("wrap",   0,0,0,0,0, 12'hFFF, 12'h000, 12'h000, 12'h000, 0, 0,0));
        vecs.push_back(mk("branch", 0,0,0,1,0, 12'h010, 12'hFFE, 12'h000, br_exp,   0, 0,0));
        vecs.push_back(mk("callwr", 0,0,1,0,0, 12'hFFF, 12'h000, 12'h300, 12'h300, 1, 0,0));
        vecs.push_back(mk("retwr",  0,1,0,0,0, 12'h301, 12'h000, 12'h000, 12'h000, 0, 0,0));
        vecs.push_back(mk("call1",  0,0,1,0,0, 12'h010, 12'h000, 12'h100, 12'h100, 1, 0,0));
        vecs.push_back(mk("call2",  0,0,1,0,0, 12'h105, 12'h000, 12'h200, 12'h200, 2, 0,0));
        vecs.push_back(mk("stall",  1,1,1,1,0, 12'h201, 12'h333, 12'h444, 12'h201, 2, 0,0));
        vecs.push_back(mk("ret1",   0,1,0,0,0, 12'h201, 12'h000, 12'h000, 12'h106, 1, 0,0));
        vecs.push_back(mk("ret2",   0,1,0,0,0, 12'h107, 12'h000, 12'h000, 12'h011, 0, 0,0));
        vecs.push_back(mk("callbr", 0,0,1,1,0, 12'h020, 12'h777, 12'h400, 12'h400, 1, 0,0));
        vecs.push_back(mk("callret",0,1,1,0,0, 12'h400, 12'h000, 12'h500, 12'h021, 0, 0,0));
        vecs.push_back(mk("undf",   0,1,0,0,0, 12'h030, 12'h000, 12'h000, 12'h031, 0, 0,1));
        vecs.push_back(mk("clr1",   0,0,0,0,1, 12'h031, 12'h000, 12'h000, 12'h032, 0, 0,0));
        vecs.push_back(mk("ov_c1",  0,0,1,0,0, 12'h100, 12'h000, 12'h110, 12'h110, 1, 0,0));
        vecs.push_back(mk("ov_c2",  0,0,1,0,0, 12'h200, 12'h000, 12'h210, 12'h210, 2, 0,0));
        vecs.push_back(mk("ov_c3",  0,0,1,0,0, 12'h300, 12'h000, 12'h310, 12'h310, 3, 0,0));
        vecs.push_back(mk("ov_c4",  0,0,1,0,0, 12'h400, 12'h000, 12'h410, 12'h410, 4, 0,0));
        vecs.push_back(mk("ov_c5",  0,0,1,0,1, 12'h500, 12'h000, 12'h510, 12'h510, 4, 1,0));
        vecs.push_back(mk("ov_r1",  0,1,0,0,0, 12'h600, 12'h000, 12'h000, 12'h501, 3, 1,0));
        vecs.push_back(mk("ov_r2",  0,1,0,0,0, 12'h600, 12'h000, 12'h000, 12'h401, 2, 1,0));
        vecs.push_back(mk("ov_r3",  0,1,0,0,0, 12'h600, 12'h000, 12'h000, 12'h301, 1, 1,0));
        vecs.push_back(mk("ov_r4",  0,1,0,0,0, 12'h600, 12'h000, 12'h000, 12'h201, 0, 1,0));
        vecs.push_back(mk("ov_r5",  0,1,0,0,0, 12'h600, 12'h000, 12'h000, 12'h601, 0, 1,1));
        vecs.push_back(mk("clr2",   0,0,0,0,1, 12'h601, 12'h000, 12'h000, 12'h602, 0, 0,0));

        // Reset held two cycles with requests active: pc_next must read 0.
        idle_inputs();
        reset = 1; pc_cur = 12'h0AB; call = 1; call_target = 12'h555;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst.pc_next", 32'(pc_next), 32'h0);
            @(posedge clk); #1;
        end
        chk("rst.depth", 32'(ras_depth), 32'h0);
        chk("rst.ovf", 32'(ras_overflow), 32'h0);
        chk("rst.unf", 32'(ras_underflow), 32'h0);

        // Free-run from PC 0: 0,1,2,3 with the bench acting as the PC register.
        idle_inputs();
        reset = 0; pc_cur = '0;
        for (int i = 0; i < 4; i++) begin
            chk("run.pc_cur", 32'(pc_cur), 32'(i));
            #1;
            chk("run.pc_next", 32'(pc_next), 32'(i + 1));
            @(posedge clk); #1;
            pc_cur = AW'(i + 1);
            chk("run.depth", 32'(ras_depth), 32'h0);
        end

        foreach (vecs[i]) apply(vecs[i]);

        // Reset with nested calls outstanding empties the stack; next ret underflows.
        idle_inputs();
        apply(mk("mr_c1", 0,0,1,0,0, 12'h040, 12'h000, 12'h080, 12'h080, 1, 0,0));
        apply(mk("mr_c2", 0,0,1,0,0, 12'h081, 12'h000, 12'h0C0, 12'h0C0, 2, 0,0));
        idle_inputs();
        reset = 1; ret = 1;
        #1;
        chk("mr_rst.pc_next", 32'(pc_next), 32'h0);
        @(posedge clk); #1;
        chk("mr_rst.depth", 32'(ras_depth), 32'h0);
        reset = 0;
        apply(mk("mr_ret", 0,1,0,0,0, 12'h0C1, 12'h000, 12'h000, 12'h0C2, 0, 0,1));

        if (exp_q.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL scoreboard: got %0d leftover expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/next_pc_logic.md
Name: next_pc_logic

Overview:
- Next-PC generator directly upstream of the program counter register.
- Drives the program counter's load input every cycle from the current PC, stall, branch, call and return requests.
- Owns a return-address stack (RAS) so call/return resolve without a memory round-trip.
- The program counter register stays a plain loadable register; all sequencing decisions live here.

Parameters:
ADDR_W, 12, PC/address width in bits.
RAS_DEPTH, 4, number of RAS entries (power of two, 2..16).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
pc_cur  input  ADDR_W  current PC, taken from the program counter output
stall  input  1  hold PC; no RAS change
branch_taken  input  1  redirect to branch_target
branch_target  input  ADDR_W  branch destination (absolute; see Optional Feature)
call  input  1  push return address, jump to call_target
call_target  input  ADDR_W  call destination (always absolute)
ret  input  1  pop RAS, jump to popped address
clear_flags  input  1  clears sticky error flags
pc_next  output  ADDR_W  next PC value, fed to the program counter load input
ras_depth  output  $clog2(RAS_DEPTH)+1  number of valid RAS entries
ras_overflow  output  1  sticky; a push happened while full
ras_underflow  output  1  sticky; a pop happened while empty

Interface note:
- One clock, clk.
- Reset is synchronous and active-high, port name reset.
- Polarity and synchronicity are fixed.

Behaviour:
- pc_next is combinational from current inputs and the registered RAS top. There is no added latency: the program counter captures it on the same edge.
- While reset=1:
  - pc_next=0.
  - RAS pointer, ras_depth, ras_overflow and ras_underflow all clear on the clock edge.
  - RAS contents are don't-care.
- Selection priority, highest first:
  - stall: pc_next=pc_cur. All other requests are ignored and the RAS is unchanged.
  - ret:
    - If depth>0: pc_next=RAS top; pop on the edge.
    - If depth=0: pc_next=pc_cur+1, ras_underflow set, depth stays 0.
  - call: pc_next=call_target; push pc_cur+1 on the edge.
  - branch_taken: pc_next=branch_target.
  - Otherwise: pc_next=pc_cur+1.
- Simultaneous ret and call: ret wins, call ignored, no push.
- Simultaneous call and branch_taken: call wins.
- All address arithmetic is modulo 2^ADDR_W. 0xFFF+1 wraps to 0x000, both for the sequential PC and for a pushed return address.
- RAS is a circular buffer with a write pointer.
  - Push while depth<RAS_DEPTH: store at the pointer, pointer+1, depth+1.
  - Push while full: overwrite the oldest entry (pointer wraps), depth stays RAS_DEPTH, ras_overflow set.
  - Pop: pointer-1, depth-1.
  - Pops after an overflow return the most recent RAS_DEPTH addresses only.
- Sticky flags:
  - Set by the events above.
  - Cleared only by reset or by clear_flags=1 on an edge.
  - If clear_flags and a setting event occur in the same cycle, set wins.
- Reset asserted mid-sequence (e.g. nested calls outstanding): the stack is emptied. Any subsequent ret underflows.

Optional Feature:
- Macro NPC_REL_BRANCH_EN.
- Defined: branch_target is a two's-complement offset, and pc_next = pc_cur + branch_target (mod 2^ADDR_W). Example: pc_cur=0x010, target=0xFFE gives 0x00E.
- Undefined: branch_target is absolute.
- call_target is absolute in both builds.

Decomposition:
- Shared package npc_pkg:
  - ADDR_W_DEF=12, RAS_DEPTH_DEF=4.
  - Enumerated select type npc_sel_t {SEL_HOLD, SEL_RET, SEL_CALL, SEL_BRANCH, SEL_SEQ}, also used by trace/debug logic.
- Sub-module ras_stack:
  - Circular storage, pointer, depth, overflow/underflow detection.
  - Ports: push, pop, push_data, top, depth, full, empty.
  - next_pc_logic holds only the priority mux and the sticky flags.

Test Plan:
- Reset then free-run: reset=1 for 2 cycles, release -> pc_next=0 during reset; PC sequence 0,1,2,3; ras_depth=0.
- Wrap: pc_cur=0xFFF, no requests -> pc_next=0x000. Call at pc_cur=0xFFF -> pushed return address is 0x000.
- Nested call/return: calls at 0x010 (to 0x100) and 0x105 (to 0x200), then two rets -> pc_next 0x106 then 0x011; ras_depth 1,2,1,0.
- Overflow: 5 calls with RAS_DEPTH=4 -> ras_overflow=1, depth=4; 4 rets return the last four return addresses; a 5th ret sets ras_underflow and gives pc_cur+1.
- Stall and priority:
  - stall with call+ret+branch asserted -> pc_next=pc_cur, depth unchanged.
  - call+ret together with depth=1 -> pop only.
  - clear_flags coinciding with an overflow event -> flag stays 1.
- NPC_REL_BRANCH_EN build: pc_cur=0x010, branch_taken, target=0xFFE -> 0x00E. Non-macro build, same stimulus -> 0xFFE.
